// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN frame controller.
package snn_pkg;

  // Frame controller states: collect bytes, kick the core, wait on it, hand off the result.
  typedef enum logic [1:0] {
    RX     = 2'd0,
    START  = 2'd1,
    CORE   = 2'd2,
    TX_REQ = 2'd3
  } state_e;

  // Byte sent in place of a digit when the core watchdog expires.
  localparam logic [7:0] TX_ERR_BYTE = 8'hFF;

  // Bytes in one 28x28 image after 8:1 pixel packing.
  localparam int FRAME_BYTES_DEFAULT = 98;

endpackage : snn_pkg

// File: rtl/snn_wdog.sv
// Up-counter with synchronous clear and count enable. expire is high while the
// count equals LIMIT-1, so LIMIT enabled cycles after a clear have elapsed when
// the expiring cycle ends.
module snn_wdog #(
  parameter int LIMIT = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear has priority over enable.
  always_comb begin
    // NOTE: assigning a default first means every path writes cnt_d, so no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == W'(LIMIT - 1));

endmodule : snn_wdog

// File: rtl/snn_frame_ctrl.sv
// Frame-level controller for the SNN classifier: gathers FRAME_BYTES UART bytes
// into the input RAM, starts the core, waits for its digit under a watchdog and
// hands one result byte to the UART transmitter.
// Optional build macro SNN_RX_TIMEOUT_EN adds an inter-byte idle timer that
// discards a stalled partial frame and raises err_rx_timeout.
module snn_frame_ctrl
  import snn_pkg::*;
#(
  parameter int FRAME_BYTES  = FRAME_BYTES_DEFAULT,
  parameter int ADDR_W       = 7,
  parameter int RESULT_W     = 4,
  parameter int CORE_TIMEOUT = 65536
`ifdef SNN_RX_TIMEOUT_EN
  ,
  parameter int RX_TIMEOUT   = 5_000_000
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_rdy,
  input  logic [7:0]          rx_data,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [7:0]          ram_wdata,
  output logic                core_start,
  input  logic                core_done,
  input  logic [RESULT_W-1:0] core_digit,
  input  logic                tx_rdy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic [RESULT_W-1:0] result,
  output logic                busy,
  output logic [15:0]         frame_cnt,
  input  logic                clr_err,
  output logic                err_overrun,
`ifdef SNN_RX_TIMEOUT_EN
  output logic                err_rx_timeout,
`endif
  output logic                err_timeout
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [RESULT_W-1:0] result_q, result_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic                err_overrun_q, err_overrun_d;
  logic                err_timeout_q, err_timeout_d;
  logic                core_expire;

  // The core watchdog restarts in START and runs only while waiting in CORE.
  snn_wdog #(.LIMIT(CORE_TIMEOUT)) u_core_wdog (
    .clk   (clk),
    .rst   (rst),
    .clr   (state_q == START),
    .en    (state_q == CORE),
    .expire(core_expire)
  );

`ifdef SNN_RX_TIMEOUT_EN
  logic err_rx_timeout_q, err_rx_timeout_d;
  logic rx_idle_en;
  logic rx_idle_expire;
  logic rx_abort;

  // Idle timer runs only inside a partial frame and restarts on every byte.
  assign rx_idle_en = (state_q == RX) && (cnt_q != '0) && !rx_rdy;
  assign rx_abort   = rx_idle_en && rx_idle_expire;

  snn_wdog #(.LIMIT(RX_TIMEOUT)) u_rx_idle (
    .clk   (clk),
    .rst   (rst),
    .clr   (!rx_idle_en || rx_abort),
    .en    (rx_idle_en),
    .expire(rx_idle_expire)
  );
`endif

  // Next-state, strobe outputs and register updates for the frame sequence.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    result_d      = result_q;
    tx_data_d     = tx_data_q;
    frame_cnt_d   = frame_cnt_q;
    err_overrun_d = err_overrun_q;
    err_timeout_d = err_timeout_q;
    ram_we        = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    core_start    = 1'b0;
    tx_start      = 1'b0;
`ifdef SNN_RX_TIMEOUT_EN
    err_rx_timeout_d = err_rx_timeout_q;
`endif

    // Clear first so that any set event below overrides it in the same cycle.
    if (clr_err) begin
      err_overrun_d = 1'b0;
      err_timeout_d = 1'b0;
`ifdef SNN_RX_TIMEOUT_EN
      err_rx_timeout_d = 1'b0;
`endif
    end

    unique case (state_q)
      RX: begin
        if (rx_rdy) begin
          ram_we    = 1'b1;
          ram_addr  = cnt_q;
          ram_wdata = rx_data;
          if (cnt_q == ADDR_W'(FRAME_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
`ifdef SNN_RX_TIMEOUT_EN
        else if (rx_abort) begin
          cnt_d            = '0;
          err_rx_timeout_d = 1'b1;
        end
`endif
      end
      START: begin
        core_start = 1'b1;
        state_d    = CORE;
      end
      CORE: begin
        // A done strobe in the expiring cycle still delivers the real digit.
        if (core_done) begin
          result_d  = core_digit;
          tx_data_d = 8'(core_digit);
          state_d   = TX_REQ;
        end else if (core_expire) begin
          err_timeout_d = 1'b1;
          tx_data_d     = TX_ERR_BYTE;
          state_d       = TX_REQ;
        end
      end
      TX_REQ: begin
        if (tx_rdy) begin
          tx_start    = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = RX;
        end
      end
      default: state_d = RX;
    endcase

    // Bytes arriving outside RX are dropped and flagged.
    if (rx_rdy && (state_q != RX)) begin
      err_overrun_d = 1'b1;
    end

    // No strobes leave the block while reset is being applied.
    if (rst) begin
      ram_we     = 1'b0;
      ram_addr   = '0;
      ram_wdata  = '0;
      core_start = 1'b0;
      tx_start   = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RX;
      cnt_q         <= '0;
      result_q      <= '0;
      tx_data_q     <= '0;
      frame_cnt_q   <= '0;
      err_overrun_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      result_q      <= result_d;
      tx_data_q     <= tx_data_d;
      frame_cnt_q   <= frame_cnt_d;
      err_overrun_q <= err_overrun_d;
      err_timeout_q <= err_timeout_d;
    end
  end

`ifdef SNN_RX_TIMEOUT_EN
  // Sticky partial-frame timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_rx_timeout_q <= 1'b0;
    end else begin
      err_rx_timeout_q <= err_rx_timeout_d;
    end
  end

  assign err_rx_timeout = err_rx_timeout_q;
`endif

  assign busy        = (state_q != RX);
  assign tx_data     = tx_data_q;
  assign result      = result_q;
  assign frame_cnt   = frame_cnt_q;
  assign err_overrun = err_overrun_q;
  assign err_timeout = err_timeout_q;

endmodule : snn_frame_ctrl
